// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Parametrised UART receiver. A 2-flop synchronizer feeds a mid-bit sampling
// FSM that rejects start-bit glitches, checks parity and stop bits, and
// refuses to decode a held-low line (break) as a new frame. Received words
// are presented through a valid/ready register; a frame that completes while
// the register is still occupied is dropped and flagged with `overrun`.
//
// Parameters
//   CLK_FREQ     input clock frequency in Hz
//   BAUD         line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (truncated, >= 2)
//   DATA_BITS    data bits per frame, 5..9, LSB first
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//
// Ports
//   clk50MHz    in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   rx          in   serial line, idles high, asynchronous
//   data_out    out  received word, stable while data_valid is high
//   data_valid  out  a word is held in the output register
//   data_ready  in   consumer accepts (transfer = data_valid && data_ready)
//   parity_err  out  parity mismatch for the held word
//   frame_err   out  a stop bit of the held word was sampled low
//   overrun     out  one-cycle pulse: a completed frame was dropped
//   busy        out  receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 2
) (
  input  logic                 clk50MHz,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_EN    = (PARITY_MODE != 0);
  localparam logic              PAR_ODD   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  // Parity error for a word plus its received parity bit: even parity errs
  // when the total number of ones is odd; odd parity is the inverse.
  function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] data,
                                           input logic                 par_bit,
                                           input logic                 odd);
    calc_parity_err = (^{data, par_bit}) ^ odd;
  endfunction

  logic [1:0]           sync_q, sync_d;
  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 line_s;
  logic                 xfer_s;
  logic                 ferr_now_s;

  assign line_s = sync_q[1];

  // Next-state logic for the synchronizer, receive FSM and output register.
  always_comb begin
    sync_d     = {sync_q[0], rx};
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    ferr_now_s = ferr_q | ~line_s;
    xfer_s     = valid_q & data_ready;

    // A transfer empties the register; a completion below may refill it.
    if (xfer_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!line_s) begin
          state_d    = S_START;
          baud_cnt_d = BAUD_ZERO;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = BAUD_ZERO;
          // Line back high at mid-start: treat as a glitch, not a frame.
          if (line_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = BIT_ZERO;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d = BAUD_ZERO;
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d    = {line_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = BIT_ZERO;
            if (PAR_EN) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end

      S_PARITY: begin
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d = BAUD_ZERO;
          perr_d     = calc_parity_err(shift_q, line_s, PAR_ODD);
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (baud_cnt_q == FULL_LAST) begin
          baud_cnt_d = BAUD_ZERO;
          ferr_d     = ferr_now_s;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = BIT_ZERO;
            // A low final stop bit may be a break: wait for the line to
            // recover so the held-low level is not taken as a start bit.
            if (line_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DRAIN;
            end
            // The register is free if empty or being emptied this cycle.
            if (!valid_q || xfer_s) begin
              data_d     = shift_q;
              valid_d    = 1'b1;
              perr_out_d = PAR_EN ? perr_q : 1'b0;
              ferr_out_d = ferr_now_s;
            end else begin
              overrun_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_ONE;
        end
      end

      S_DRAIN: begin
        if (line_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      baud_cnt_q <= BAUD_ZERO;
      bit_cnt_q  <= BIT_ZERO;
      shift_q    <= {DATA_BITS{1'b0}};
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= {DATA_BITS{1'b0}};
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised UART receiver: the next generation of the fixed-format `uart` receive path. Word width, parity mode, stop-bit count and baud divisor are set by parameters, and the block adds start-bit glitch rejection, error flags and a valid/ready output handshake with overrun detection. It sits between the board-level `rx` pin and any on-chip consumer, such as a FIFO or command decoder, in the `clk50MHz` domain.

## Interface
- `CLK_FREQ`, 50000000: input clock frequency in Hz.
- `BAUD`, 9600: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer-truncated (5208 at defaults).
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, LSB first.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 2: legal values 1 or 2.

- `clk50MHz`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk50MHz`.
- `data_out`  out  DATA_BITS  received word; stable while `data_valid` is high.
- `data_valid`  out  1  a word is held in the output register.
- `data_ready`  in  1  consumer accepts; transfer happens when `data_valid && data_ready`.
- `parity_err`  out  1  parity mismatch for the held word; qualified by `data_valid`.
- `frame_err`  out  1  a stop bit was sampled low for the held word; qualified by `data_valid`.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. Below, "line" means the synchronized value.
- Bit counter `bit_cnt` is wide enough for DATA_BITS. Baud counter `baud_cnt` is wide enough for CLKS_PER_BIT.
- FSM states:
  - IDLE: a line value of 0 moves the FSM to START and clears `baud_cnt`.
  - START: waits CLKS_PER_BIT/2 cycles, then samples the line. 0 moves to DATA. 1 is a glitch and returns to IDLE with no output.
  - DATA: samples every CLKS_PER_BIT cycles and shifts the sample into the MSB of a shift register, so the LSB-first stream ends up in the correct order. After DATA_BITS samples it moves to PARITY, or to STOP if `PARITY_MODE == 0`.
  - PARITY: takes one sample and computes `perr = ^{data, sample}` for even, or its inverse for odd.
  - STOP: takes STOP_BITS samples, each CLKS_PER_BIT apart. Any sample of 0 sets `ferr`.
  - DRAIN: entered only if the last stop sample was 0 (break or misframe). Waits for the line to return to 1, then goes to IDLE. A break must never be decoded as a new start.
- Completion happens on the cycle of the final stop sample:
  - If `data_valid` is 0, or a transfer occurs on that same cycle, then `data_out`, `parity_err` and `frame_err` are loaded and `data_valid` is set.
  - Otherwise the new frame is discarded, `overrun` pulses, and the held word and flags are unchanged.
- `data_valid` clears on the cycle after a transfer unless a completion reloads it on that same cycle.
- Unused parity: `parity_err` is always 0.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. FSM in IDLE, counters 0.
- `rst` mid-frame aborts the frame immediately and nothing is delivered. The next falling edge after release starts a fresh frame.
- Start detect occurs 2 cycles after the `rx` falling edge because of the synchronizer.
- Sample instants are at CLKS_PER_BIT/2 + k·CLKS_PER_BIT cycles after start detect, k = 0..N−1, where N = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS.
- `data_valid` rises 1 cycle after the final stop sample.
- `busy` goes high 1 cycle after start detect. It goes low 1 cycle after the final stop sample, or 1 cycle after the line returns high when in DRAIN.
- The next start can be detected on the cycle after the FSM returns to IDLE. Back-to-back frames with no idle gap must be received.
- `data_ready` may be held high permanently; each word is then visible for exactly 1 cycle.

## Test plan
1. Default parameters, 20 ns clock, 5208 cycles/bit. Send 0x2D LSB first (1,0,1,1,0,1,0,0), parity 0, two stop bits. Expect `data_out` = 0x2D, `data_valid` = 1, `parity_err` = 0, `frame_err` = 0.
2. Same frame with parity bit 1. Expect `data_out` = 0x2D, `parity_err` = 1. With `PARITY_MODE` = 2 the original frame gives `parity_err` = 1.
3. Send 0x55 with the second stop bit 0, and hold `rx` low for 3 bit times. Expect `frame_err` = 1 and `busy` high until `rx` rises, then exactly one delivered word, with no spurious second frame.
4. Pull `rx` low for 1000 cycles, then high. Expect no `data_valid`, and `busy` returns to 0 after the mid-start sample.
5. With `data_ready` = 0, send 0x11 then 0x22 back-to-back. Expect `data_out` = 0x11 held and one `overrun` pulse. Raise `data_ready` and expect a single transfer of 0x11, after which `data_valid` = 0.
6. Assert `rst` during data bit 4 of a frame. Expect all outputs 0 and no delivery. Then send 0xA3 with `DATA_BITS` = 8 and expect `data_out` = 0xA3. Repeat with `DATA_BITS` = 7, `STOP_BITS` = 1, `PARITY_MODE` = 0 and expect `data_out` = 0x23.
